// File: rtl/cpu_ctrl_seq.sv
// Multicycle control sequencer for the 16-bit CPU datapath: opcode decode,
// memory handshake with timeout, branching, HALT/FAULT and a retired-instruction count.
module cpu_ctrl_seq #(
    parameter int OPW     = 5,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [15:0]      opcode,
    input  logic             mem_ready,
    input  logic             br_cond,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IR_EN,
    output logic             PC_EN,
    output logic             MDR_EN,
    output logic             BR_EN,
    output logic             RFwrite,
    output logic             LDW_EN,
    output logic             dataW_MDR,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    // state    | meaning
    // IDLE     | post-reset, one cycle    FETCH/FETCH_IR | read instr, bump PC / load IR
    // DECODE   | classify opcode          ALU/ALU_WB     | execute / write register file
    // LDW_*    | load: mem, MDR, write    STW            | store, wait for mem_ready
    // BR       | conditional PC load      HALT/FAULT     | terminal until reset
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_FETCH_IR, S_DECODE, S_ALU, S_ALU_WB,
        S_LDW_MEM, S_LDW_MDR, S_LDW_WB, S_STW, S_BR, S_HALT, S_FAULT
    } state_t;

    localparam logic [OPW-1:0] OP_BR   = OPW'(17);
    localparam logic [OPW-1:0] OP_STW  = OPW'(18);
    localparam logic [OPW-1:0] OP_LDW  = OPW'(19);
    localparam logic [OPW-1:0] OP_HALT = OPW'(20);

    state_t          state, state_nxt;
    logic [TO_W-1:0] wcnt;
    logic [OPW-1:0]  op;
    logic            in_wait, timeout, cnt_inc;
    logic            unused_opcode;

    assign op            = opcode[OPW-1:0];
    assign unused_opcode = &{1'b0, opcode};
    assign in_wait       = (state == S_FETCH) || (state == S_LDW_MEM) || (state == S_STW);
    assign timeout       = (TIMEOUT != 0) && (wcnt == TO_W'(TIMEOUT)) && !mem_ready;
    assign cnt_inc       = (state == S_ALU_WB) || (state == S_LDW_WB) || (state == S_BR) ||
                           ((state == S_STW) && mem_ready) ||
                           ((state == S_DECODE) && (op == OP_HALT));

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            // Wait states are never entered from another wait state while not ready,
            // so clearing whenever not counting gives a zero count on every entry.
            if (in_wait && !mem_ready)
                wcnt <= wcnt + TO_W'(1);
            else
                wcnt <= '0;
            if (cnt_inc)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IR_EN     = 1'b0;
        PC_EN     = 1'b0;
        MDR_EN    = 1'b0;
        BR_EN     = 1'b0;
        RFwrite   = 1'b0;
        LDW_EN    = 1'b0;
        dataW_MDR = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        unique case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    PC_EN     = 1'b1;
                    state_nxt = S_FETCH_IR;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                end
            end
            S_FETCH_IR: begin
                IR_EN     = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (op < OP_BR)         state_nxt = S_ALU;
                else if (op == OP_BR)   state_nxt = S_BR;
                else if (op == OP_STW)  state_nxt = S_STW;
                else if (op == OP_LDW)  state_nxt = S_LDW_MEM;
                else if (op == OP_HALT) state_nxt = S_HALT;
                else                    state_nxt = S_FAULT;
            end
            S_ALU: state_nxt = S_ALU_WB;
            S_ALU_WB: begin
                RFwrite   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_LDW_MEM: begin
                LDW_EN  = 1'b1;
                MemRead = 1'b1;
                if (mem_ready)    state_nxt = S_LDW_MDR;
                else if (timeout) state_nxt = S_FAULT;
            end
            S_LDW_MDR: begin
                LDW_EN    = 1'b1;
                MDR_EN    = 1'b1;
                state_nxt = S_LDW_WB;
            end
            S_LDW_WB: begin
                dataW_MDR = 1'b1;
                RFwrite   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_STW: begin
                LDW_EN   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready)    state_nxt = S_FETCH;
                else if (timeout) state_nxt = S_FAULT;
            end
            S_BR: begin
                BR_EN     = br_cond;
                state_nxt = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
